// File: rtl/fourbit_sync_updown_pkg.sv
// Shared constants and types for the up/down counter.
// Direction encodings match the Up_Down pin polarity.
package fourbit_sync_updown_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam int   WIDTH_DEF = 4;

  typedef logic [WIDTH_DEF-1:0] count_t;

endpackage

// File: rtl/fourbit_sync_updown_if.sv
// Direction/count bundle between a counter and the block that steers it.
// Tc exists only when FOURBIT_SYNC_UPDOWN_TC_EN is defined.
interface fourbit_sync_updown_if #(
  parameter int WIDTH = 4
);

  logic             Up_Down;
  logic [WIDTH-1:0] Count;
`ifdef FOURBIT_SYNC_UPDOWN_TC_EN
  logic             Tc;

  modport master (output Up_Down, input Count, input Tc);
  modport slave  (input Up_Down, output Count, output Tc);
`else
  modport master (output Up_Down, input Count);
  modport slave  (input Up_Down, output Count);
`endif

endinterface

// File: rtl/fourbit_sync_updown_next.sv
// Combinational next-count unit: +1/-1 modulo 2**WIDTH.
// wrap flags the step that crosses the max/zero boundary.
module updown_next
  import fourbit_sync_updown_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] cur,
  input  logic             dir,
  output logic [WIDTH-1:0] nxt,
  output logic             wrap
);

  always_comb begin
    nxt  = cur;
    wrap = 1'b0;
    if (dir == DIR_UP) begin
      nxt  = cur + WIDTH'(1);
      wrap = (cur == {WIDTH{1'b1}});
    end else begin
      nxt  = cur - WIDTH'(1);
      wrap = (cur == {WIDTH{1'b0}});
    end
  end

endmodule

// File: rtl/fourbit_sync_updown.sv
// Synchronous up/down counter with synchronous active-high reset.
// Optional registered terminal-count flag Tc under FOURBIT_SYNC_UPDOWN_TC_EN.
module fourbit_sync_updown
  import fourbit_sync_updown_pkg::*;
#(
  parameter int               WIDTH   = WIDTH_DEF,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             Clk,
  input  logic             rst,
  input  logic             Up_Down,
  output logic [WIDTH-1:0] Count
`ifdef FOURBIT_SYNC_UPDOWN_TC_EN
  ,
  output logic             Tc
`endif
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             wrap;

  updown_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .cur  (count_q),
    .dir  (Up_Down),
    .nxt  (count_d),
    .wrap (wrap)
  );

  always_ff @(posedge Clk) begin
    if (rst) count_q <= RST_VAL;
    else     count_q <= count_d;
  end

  assign Count = count_q;

`ifdef FOURBIT_SYNC_UPDOWN_TC_EN
  logic tc_q;

  // Tc is high in the cycle whose Count is the freshly wrapped value.
  always_ff @(posedge Clk) begin
    if (rst) tc_q <= 1'b0;
    else     tc_q <= wrap;
  end

  assign Tc = tc_q;
`else
  logic unused_wrap;
  assign unused_wrap = wrap;
`endif

endmodule

// File: tb/tb_fourbit_sync_updown.sv
// Directed bench for fourbit_sync_updown; Tc checks are active with FOURBIT_SYNC_UPDOWN_TC_EN.
module tb_fourbit_sync_updown;

  localparam int W = 4;

  logic Clk;
  logic rst;
  int   tests;
  int   fails;

  fourbit_sync_updown_if #(.WIDTH(W)) bus ();

  fourbit_sync_updown #(
    .WIDTH   (W),
    .RST_VAL (4'h0)
  ) dut (
    .Clk     (Clk),
    .rst     (rst),
    .Up_Down (bus.Up_Down),
    .Count   (bus.Count)
`ifdef FOURBIT_SYNC_UPDOWN_TC_EN
    ,
    .Tc      (bus.Tc)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk_cnt(input string tag, input logic [W-1:0] exp);
    tests++;
    assert (bus.Count === exp)
      else begin
        fails++;
        $error("FAIL %s: Count observed %h expected %h", tag, bus.Count, exp);
      end
  endtask

  task automatic chk_tc(input string tag, input logic exp);
`ifdef FOURBIT_SYNC_UPDOWN_TC_EN
    tests++;
    assert (bus.Tc === exp)
      else begin
        fails++;
        $error("FAIL %s: Tc observed %b expected %b", tag, bus.Tc, exp);
      end
`else
    if (tag.len() < 0 || exp === 1'bz) tests = tests;
`endif
  endtask

  // Advance one rising edge and settle 1 ns past it before any check.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] e;
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.Up_Down = 1'b0;

    // Reset held for two edges
    step(); chk_cnt("rst_edge1", 4'h0); chk_tc("rst_tc1", 1'b0);
    step(); chk_cnt("rst_edge2", 4'h0); chk_tc("rst_tc2", 1'b0);

    // Down after reset: F, E, D, C
    rst = 1'b0;
    step(); chk_cnt("down_F", 4'hF); chk_tc("down_tc_F", 1'b1);
    step(); chk_cnt("down_E", 4'hE); chk_tc("down_tc_E", 1'b0);
    step(); chk_cnt("down_D", 4'hD); chk_tc("down_tc_D", 1'b0);
    step(); chk_cnt("down_C", 4'hC);

    // Up after reset: 1 .. F, 0
    rst = 1'b1; bus.Up_Down = 1'b1;
    step(); chk_cnt("rst_up", 4'h0);
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      step();
      e = 4'(i);
      chk_cnt("up_seq", e);
      chk_tc("up_tc", (i == 16));
    end

    // Direction flip at 3: 2, 1, 0, F
    step(); chk_cnt("flip_up1", 4'h1);
    step(); chk_cnt("flip_up2", 4'h2);
    step(); chk_cnt("flip_up3", 4'h3);
    bus.Up_Down = 1'b0;
    step(); chk_cnt("flip_dn2", 4'h2);
    step(); chk_cnt("flip_dn1", 4'h1);
    step(); chk_cnt("flip_dn0", 4'h0); chk_tc("flip_tc0", 1'b0);
    step(); chk_cnt("flip_dnF", 4'hF); chk_tc("flip_tcF", 1'b1);

    // Reset at 9, resume upward
    bus.Up_Down = 1'b1;
    for (int i = 0; i <= 9; i++) step();
    chk_cnt("mid_at9_up", 4'h9);
    rst = 1'b1;
    step(); chk_cnt("mid_rst_up", 4'h0); chk_tc("mid_rst_tc", 1'b0);
    rst = 1'b0;
    step(); chk_cnt("mid_resume_up", 4'h1);

    // Reset at 9, resume downward
    for (int i = 2; i <= 9; i++) step();
    chk_cnt("mid_at9_dn", 4'h9);
    rst = 1'b1; bus.Up_Down = 1'b0;
    step(); chk_cnt("mid_rst_dn", 4'h0);
    rst = 1'b0;
    step(); chk_cnt("mid_resume_dn", 4'hF); chk_tc("mid_resume_tc", 1'b1);

    // 3 ns rst pulse between edges must be ignored
    #2 rst = 1'b1;
    #3 rst = 1'b0;
    chk_cnt("glitch_hold", 4'hF);
    step(); chk_cnt("glitch_next", 4'hE); chk_tc("glitch_tc", 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
